// File: rtl/rdma2_pingpong_buf_pkg.sv
// Shared types for the rdma2 ping-pong buffer and its consumers.
package rdma2_pingpong_buf_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_state_e;

  // A bank owned by the reader side cannot take new beats.
  function automatic logic bank_is_closed(input bank_state_e st);
    return (st == BANK_FULL) || (st == BANK_DRAIN);
  endfunction

endpackage

// File: rtl/rdma2_pingpong_buf_sdp_bram.sv
// Simple dual-port RAM holding both banks; registered read with enable.
module rdma2_pingpong_buf_sdp_bram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register holds its value while the reader is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_clr) r_rdata <= '0;
    else if (i_re)  r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rdma2_pingpong_buf.sv
// Ping-pong capture buffer between rdma2 and the conv/max-pool datapath.
module rdma2_pingpong_buf
  import rdma2_pingpong_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ap_start,
  input  logic [ADDR_W:0]   fill_len,
  input  logic              rdma2_valid,
  input  logic [DATA_W-1:0] rdma2_data,
  input  logic              rdma2_done,
  output logic              bram_full,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              buf_empty
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  bank_state_e      r_bank_st [2];
  bank_state_e      w_bank_st_nxt [2];
  logic [CNT_W-1:0] r_len [2];
  logic [CNT_W-1:0] w_len_nxt [2];
  logic             r_wb, r_rb, w_wb_nxt, w_rb_nxt;
  logic [CNT_W-1:0] r_wcnt, r_rcnt, w_wcnt_nxt, w_rcnt_nxt;
  logic [CNT_W-1:0] r_fill_len;
  logic             r_out_valid, r_out_last, w_out_valid_nxt, w_out_last_nxt;
  logic             r_start_d, r_done_d;

  logic             w_start, w_done_rise;
  logic             w_wr_en, w_wr_close, w_flush, w_issue, w_rd_last;
  logic [CNT_W-1:0] w_wcnt_inc, w_flush_cnt;

  assign w_start     = ap_start & ~r_start_d;
  assign w_done_rise = rdma2_done & ~r_done_d;

  // Write side: accept into the write bank unless it is owned by the reader.
  assign w_wr_en     = rdma2_valid && !bank_is_closed(r_bank_st[r_wb]) && !w_start;
  assign w_wcnt_inc  = r_wcnt + CNT_W'(1);
  assign w_wr_close  = w_wr_en && (w_wcnt_inc == r_fill_len);
  // A beat on the done edge is counted before the flush decides the length.
  assign w_flush_cnt = w_wr_en ? w_wcnt_inc : r_wcnt;
  assign w_flush     = w_done_rise && !w_wr_close && (w_flush_cnt != '0) && !w_start;

  // Read side: one BRAM read per cycle whenever the output register can move.
  assign w_issue   = bank_is_closed(r_bank_st[r_rb]) && (r_rcnt < r_len[r_rb])
                     && (!r_out_valid || out_ready) && !w_start;
  assign w_rd_last = (r_rcnt + CNT_W'(1)) == r_len[r_rb];

  always_comb begin
    w_bank_st_nxt   = r_bank_st;
    w_len_nxt       = r_len;
    w_wb_nxt        = r_wb;
    w_rb_nxt        = r_rb;
    w_wcnt_nxt      = r_wcnt;
    w_rcnt_nxt      = r_rcnt;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;

    if (w_wr_close || w_flush) begin
      w_bank_st_nxt[r_wb] = BANK_FULL;
      w_len_nxt[r_wb]     = w_wr_close ? r_fill_len : w_flush_cnt;
      w_wcnt_nxt          = '0;
      w_wb_nxt            = ~r_wb;
    end else if (w_wr_en) begin
      w_bank_st_nxt[r_wb] = BANK_FILL;
      w_wcnt_nxt          = w_wcnt_inc;
    end

    // Reader and writer never touch the same bank on one edge.
    if (w_issue) begin
      w_out_valid_nxt = 1'b1;
      w_out_last_nxt  = w_rd_last;
      if (w_rd_last) begin
        w_bank_st_nxt[r_rb] = BANK_FREE;
        w_rcnt_nxt          = '0;
        w_rb_nxt            = ~r_rb;
      end else begin
        w_bank_st_nxt[r_rb] = BANK_DRAIN;
        w_rcnt_nxt          = r_rcnt + CNT_W'(1);
      end
    end else if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_start) begin
      w_bank_st_nxt[0] = BANK_FREE;
      w_bank_st_nxt[1] = BANK_FREE;
      w_len_nxt[0]     = '0;
      w_len_nxt[1]     = '0;
      w_wb_nxt         = 1'b0;
      w_rb_nxt         = 1'b0;
      w_wcnt_nxt       = '0;
      w_rcnt_nxt       = '0;
      w_out_valid_nxt  = 1'b0;
      w_out_last_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_st[0] <= BANK_FREE;
      r_bank_st[1] <= BANK_FREE;
      r_len[0]     <= '0;
      r_len[1]     <= '0;
      r_wb         <= 1'b0;
      r_rb         <= 1'b0;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_fill_len   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_start_d    <= 1'b0;
      r_done_d     <= 1'b0;
    end else begin
      r_bank_st   <= w_bank_st_nxt;
      r_len       <= w_len_nxt;
      r_wb        <= w_wb_nxt;
      r_rb        <= w_rb_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_start_d   <= ap_start;
      r_done_d    <= rdma2_done;
      if (w_start) r_fill_len <= fill_len;
    end
  end

  rdma2_pingpong_buf_sdp_bram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_sdp_bram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start),
    .i_we    (w_wr_en),
    .i_waddr ({r_wb, r_wcnt[ADDR_W-1:0]}),
    .i_wdata (rdma2_data),
    .i_re    (w_issue),
    .i_raddr ({r_rb, r_rcnt[ADDR_W-1:0]}),
    .o_rdata (out_data)
  );

  // Decoded from registers only, so rdma2 can use it combinationally.
  assign bram_full = bank_is_closed(r_bank_st[r_wb]);
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign buf_empty = (r_bank_st[0] == BANK_FREE) && (r_bank_st[1] == BANK_FREE)
                     && !r_out_valid && (r_wcnt == '0);

endmodule

// File: tb/tb_rdma2_pingpong_buf.sv
// Directed vector table plus stall-scoreboard and async-reset sequences.
module tb_rdma2_pingpong_buf;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ap_start;
  logic [ADDR_W:0]   fill_len;
  logic              rdma2_valid;
  logic [DATA_W-1:0] rdma2_data;
  logic              rdma2_done;
  logic              bram_full;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              buf_empty;

  int errors = 0;
  int checks = 0;

  rdma2_pingpong_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ap_start    (ap_start),
    .fill_len    (fill_len),
    .rdma2_valid (rdma2_valid),
    .rdma2_data  (rdma2_data),
    .rdma2_done  (rdma2_done),
    .bram_full   (bram_full),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .buf_empty   (buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              st;
    logic [ADDR_W:0]   fl;
    logic              v;
    logic [DATA_W-1:0] d;
    logic              dn;
    logic              rdy;
    logic              e_full;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic              e_last;
    logic              e_empty;
  } vec_t;

  vec_t tbl[$];

  task automatic r(input bit st, input int fl, input bit v, input int d, input bit dn,
                   input bit rdy, input bit ef, input bit ev, input int ed, input bit el,
                   input bit ee);
    vec_t x;
    x.st = st; x.fl = (ADDR_W+1)'(fl); x.v = v; x.d = DATA_W'(d); x.dn = dn; x.rdy = rdy;
    x.e_full = ef; x.e_valid = ev; x.e_data = DATA_W'(ed); x.e_last = el; x.e_empty = ee;
    tbl.push_back(x);
  endtask

  task automatic check_outs(input string name, input bit ef, input bit ev, input int ed,
                            input bit el, input bit ee);
    checks++;
    if (bram_full !== ef || out_valid !== ev || out_data !== DATA_W'(ed) ||
        out_last !== el || buf_empty !== ee) begin
      errors++;
      $display("FAIL %s: got full=%0b valid=%0b data=%0d last=%0b empty=%0b, want full=%0b valid=%0b data=%0d last=%0b empty=%0b",
               name, bram_full, out_valid, out_data, out_last, buf_empty, ef, ev, ed, el, ee);
    end
  endtask

  task automatic start_layer(input int fl);
    ap_start = 1'b1; fill_len = (ADDR_W+1)'(fl); rdma2_valid = 1'b0; rdma2_done = 1'b0;
    @(posedge clk); #1;
    ap_start = 1'b0;
  endtask

  initial begin
    int wr, rd_exp, cyc;
    logic pv, pr, pw, pl;
    logic [DATA_W-1:0] pd;

    rst_n = 1'b0; ap_start = 1'b0; fill_len = '0; rdma2_valid = 1'b0;
    rdma2_data = '0; rdma2_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_outs("reset", 0, 0, 0, 0, 1);

    // Fill and drain, no stall
    r(1,4,0,0,0,1, 0,0,0,0,1);
    for (int i = 0; i < 4; i++) r(0,4,1,i,0,1, 0,0,0,0,0);
    r(0,4,1,4,0,1, 0,1,0,0,0);
    r(0,4,1,5,0,1, 0,1,1,0,0);
    r(0,4,1,6,0,1, 0,1,2,0,0);
    r(0,4,1,7,0,1, 0,1,3,1,0);
    r(0,4,0,0,0,1, 0,1,4,0,0);
    r(0,4,0,0,0,1, 0,1,5,0,0);
    r(0,4,0,0,0,1, 0,1,6,0,0);
    r(0,4,0,0,0,1, 0,1,7,1,0);
    r(0,4,0,0,0,1, 0,0,7,1,1);
    // Backpressure, then release, then flush of the 2-beat tail
    r(1,4,0,0,0,0, 0,0,0,0,1);
    for (int i = 0; i < 4; i++) r(0,4,1,i,0,0, 0,0,0,0,0);
    r(0,4,1,4,0,0, 0,1,0,0,0);
    r(0,4,1,5,0,0, 0,1,0,0,0);
    r(0,4,1,6,0,0, 0,1,0,0,0);
    r(0,4,1,7,0,0, 1,1,0,0,0);
    r(0,4,0,0,0,0, 1,1,0,0,0);
    r(0,4,0,0,0,1, 1,1,1,0,0);
    r(0,4,0,0,0,1, 1,1,2,0,0);
    r(0,4,0,0,0,1, 0,1,3,1,0);
    r(0,4,1,8,0,1, 0,1,4,0,0);
    r(0,4,1,9,0,1, 0,1,5,0,0);
    r(0,4,0,0,0,1, 0,1,6,0,0);
    r(0,4,0,0,0,1, 0,1,7,1,0);
    r(0,4,0,0,1,1, 0,0,7,1,0);
    r(0,4,0,0,1,1, 0,1,8,0,0);
    r(0,4,0,0,0,1, 0,1,9,1,0);
    r(0,4,0,0,0,1, 0,0,9,1,1);
    // Done exactly at a bank boundary
    r(1,4,0,0,0,1, 0,0,0,0,1);
    for (int i = 0; i < 4; i++) r(0,4,1,100+i,0,1, 0,0,0,0,0);
    r(0,4,0,0,1,1, 0,1,100,0,0);
    r(0,4,0,0,1,1, 0,1,101,0,0);
    r(0,4,0,0,1,1, 0,1,102,0,0);
    r(0,4,0,0,1,1, 0,1,103,1,0);
    r(0,4,0,0,1,1, 0,0,103,1,1);
    r(0,4,0,0,0,1, 0,0,103,1,1);
    // Beat on the done edge that completes the bank
    r(1,2,0,0,0,1, 0,0,0,0,1);
    r(0,2,1,110,0,1, 0,0,0,0,0);
    r(0,2,1,111,1,1, 0,0,0,0,0);
    r(0,2,0,0,1,1, 0,1,110,0,0);
    r(0,2,0,0,1,1, 0,1,111,1,0);
    r(0,2,0,0,0,1, 0,0,111,1,1);
    // Beat on the done edge that does not complete the bank
    r(1,4,0,0,0,1, 0,0,0,0,1);
    r(0,4,1,120,0,1, 0,0,0,0,0);
    r(0,4,1,121,1,1, 0,0,0,0,0);
    r(0,4,0,0,1,1, 0,1,120,0,0);
    r(0,4,0,0,1,1, 0,1,121,1,0);
    r(0,4,0,0,0,1, 0,0,121,1,1);
    // Mid-run clear after 3 of 4 beats, new layer of length 2
    r(1,4,0,0,0,1, 0,0,0,0,1);
    r(0,4,1,30,0,1, 0,0,0,0,0);
    r(0,4,1,31,0,1, 0,0,0,0,0);
    r(0,4,1,32,0,1, 0,0,0,0,0);
    r(1,2,0,0,0,1, 0,0,0,0,1);
    r(0,2,1,40,0,1, 0,0,0,0,0);
    r(0,2,1,41,0,1, 0,0,0,0,0);
    r(0,2,1,42,0,1, 0,1,40,0,0);
    r(0,2,1,43,0,1, 0,1,41,1,0);
    r(0,2,0,0,0,1, 0,1,42,0,0);
    r(0,2,0,0,0,1, 0,1,43,1,0);
    r(0,2,0,0,0,1, 0,0,43,1,1);

    foreach (tbl[i]) begin
      ap_start = tbl[i].st; fill_len = tbl[i].fl; rdma2_valid = tbl[i].v;
      rdma2_data = tbl[i].d; rdma2_done = tbl[i].dn; out_ready = tbl[i].rdy;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_full, tbl[i].e_valid,
                 int'(tbl[i].e_data), tbl[i].e_last, tbl[i].e_empty);
    end
    ap_start = 1'b0; rdma2_valid = 1'b0; rdma2_done = 1'b0;

    // Random output stall over 64 words, fill_len=16
    start_layer(16);
    wr = 0; rd_exp = 0;
    for (cyc = 0; cyc < 3000 && rd_exp < 64; cyc++) begin
      rdma2_valid = !bram_full && (wr < 64);
      rdma2_data  = DATA_W'(wr);
      out_ready   = 1'($urandom_range(0, 1));
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pw = rdma2_valid;
      if (pv && pr) begin
        checks++;
        if (pd !== DATA_W'(rd_exp) || pl !== (rd_exp % 16 == 15)) begin
          errors++;
          $display("FAIL stall_order: got data=%0d last=%0b, want data=%0d last=%0b",
                   pd, pl, rd_exp, (rd_exp % 16 == 15));
        end
        rd_exp++;
      end
      @(posedge clk); #1;
      if (pw) wr++;
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%0d last=%0b, want valid=1 data=%0d last=%0b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
    end
    rdma2_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rd_exp != 64) begin
      errors++;
      $display("FAIL stall_count: got %0d words, want 64", rd_exp);
    end
    @(posedge clk); #1;
    check_outs("stall_end", 0, 0, 63, 1, 1);

    // Asynchronous reset while a word is pending
    start_layer(2);
    out_ready = 1'b0;
    rdma2_valid = 1'b1; rdma2_data = DATA_W'(50);
    @(posedge clk); #1;
    rdma2_data = DATA_W'(51);
    @(posedge clk); #1;
    rdma2_valid = 1'b0;
    @(posedge clk); #1;
    check_outs("pre_async_rst", 0, 1, 50, 0, 0);
    #1 rst_n = 1'b0;
    #1 check_outs("async_rst", 0, 0, 0, 0, 1);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_outs("post_async_rst", 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
